sprite_line_evaluator: RTL and testbench
========================================

// Module: sprite_line_evaluator
// PURPOSE
//  Per-scanline sprite evaluation for the PPU: scans primary OAM, copies entries in range of the
//  next line into secondary OAM, reports sprite count, sprite-0 hit candidacy and overflow.
//  Parametrised successor to the fixed 8-sprite evaluation in the sprite path: configurable OAM
//  depth, sprites per line and overflow mode. Sits between OAM RAM and the sprite fetch/shift logic.
// PARAMETERS
//  NUM_OAM_ENTRIES   64  primary OAM entries (4 bytes each), power of two, 2..64
//  SPRITES_PER_LINE  8   secondary OAM slots (4 bytes each), 1..32
//  OVERFLOW_MODE     0   0 = accurate overflow detect; 1 = 2C02 diagonal-scan bug emulation
// PORTS
//  CLK             in   1    PPU master clock
//  RST             in   1    asynchronous reset, active-high
//  tick            in   1    dot enable; all state advances only when tick=1
//  start           in   1    begin evaluation of line lineCount+1 (sampled on tick)
//  lineCount       in   9    current scanline 0..261
//  spriteSize      in   1    0 = 8-line sprites, 1 = 16-line
//  clearOverflow   in   1    clear sticky overflow (pre-render line)
//  oamReadAddr     out  8    primary OAM byte address (registered)
//  oamReadData     in   8    OAM byte; valid on tick following address issue
//  secWrEn         out  1    secondary OAM write strobe (one tick)
//  secWrAddr       out  SW   secondary byte address, SW = $clog2(SPRITES_PER_LINE*4)
//  secWrData       out  8    secondary write data
//  spriteCount     out  CW   sprites copied, CW = $clog2(SPRITES_PER_LINE+1)
//  sprite0InRange  out  1    entry 0 was copied this line
//  spriteOverflow  out  1    sticky overflow flag
//  done            out  1    high from end of evaluation until next start
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except done=1; n (entry idx), m (byte offset) = 0.
//  States: IDLE -> CLEAR -> ISSUE_Y -> CHECK_Y -> COPY1 -> COPY2 -> COPY3 -> ISSUE_Y ... -> DONE.
//  start (any state, incl. mid-scan): restart at CLEAR; spriteCount, sprite0InRange, done -> 0.
//  CLEAR: SPRITES_PER_LINE*4 ticks writing 8'hFF to secondary addr 0..max, ascending.
//  ISSUE_Y: oamReadAddr = n*4+m (m=0 unless bug mode); 1 tick.
//  CHECK_Y: Y = oamReadData; diff = {1'b0,lineCount} - {1'b0,Y} (10-bit);
//    inRange = (diff >= 0) && (diff < (spriteSize ? 16 : 8)).
//    slots free & inRange: write Y to slot spriteCount byte 0, issue n*4+1, -> COPY1.
//    slots free & !inRange: n++ -> ISSUE_Y.
//    slots full & inRange: set spriteOverflow -> DONE.
//    slots full & !inRange: n++; OVERFLOW_MODE=1 also m=(m+1)%4 (no carry into n); -> ISSUE_Y.
//  COPY1..3: write sampled byte k to slot byte k, issue next address; COPY3 also spriteCount++,
//    sprite0InRange |= (n==0), n++, -> ISSUE_Y.
//  Cost: out-of-range entry 2 ticks, copied entry 5 ticks.
//  n wrapping past NUM_OAM_ENTRIES-1 -> DONE (no overflow). DONE holds until start.
//  Overflow sticky; clearOverflow clears it; set and clear in same tick: set wins.
//  lineCount >= 240: evaluation runs normally (range check handles it); Y>=240 never in range
//    for lines 0..239 unless lineCount>=Y.
//  tick=0: no state, address or output change; secWrEn forced 0.
//  Async RST mid-scan: immediate return to reset values; no partial writes afterward.
// TESTING
//  1 All Y=8'hFF, lineCount=100, start -> 32 FF writes, 128 scan ticks, spriteCount=0, done=1, no overflow.
//  2 Entries 0,5 Y=96, tile/attr/x 11,22,33, lineCount=100 -> slots 0,1 = {96,11,22,33}, count=2, sprite0InRange=1.
//  3 Nine entries Y=50, lineCount=55, mode 0 -> count=8, overflow=1, done right after 9th CHECK_Y.
//  4 Y=40, lineCount=50: spriteSize=0 -> not copied; spriteSize=1 -> copied; lineCount=39 -> never copied.
//  5 Mode 1, 8 in range, entry 9 Y=0 but byte1 of entry 10 =55, line 55 -> overflow from diagonal read at addr 41.
//  6 start reasserted mid-COPY2, then RST mid-CLEAR -> restart CLEAR; after RST done=1, outputs 0, clearOverflow+set same tick -> 1.

Source files
------------

// File: rtl/sprite_line_evaluator.sv
// Per-scanline sprite evaluation: scans primary OAM, copies entries in range of the next
// line into secondary OAM and reports sprite count, sprite-0 candidacy and sticky overflow.
module sprite_line_evaluator #(
    parameter int NUM_OAM_ENTRIES  = 64,
    parameter int SPRITES_PER_LINE = 8,
    parameter int OVERFLOW_MODE    = 0,
    localparam int SW = $clog2(SPRITES_PER_LINE * 4),
    localparam int CW = $clog2(SPRITES_PER_LINE + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          tick,
    input  logic          start,
    input  logic [8:0]    lineCount,
    input  logic          spriteSize,
    input  logic          clearOverflow,
    output logic [7:0]    oamReadAddr,
    input  logic [7:0]    oamReadData,
    output logic          secWrEn,
    output logic [SW-1:0] secWrAddr,
    output logic [7:0]    secWrData,
    output logic [CW-1:0] spriteCount,
    output logic          sprite0InRange,
    output logic          spriteOverflow,
    output logic          done
);

    localparam int NW = $clog2(NUM_OAM_ENTRIES);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ISSUE_Y,
        CHECK_Y,
        COPY1,
        COPY2,
        COPY3,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [NW-1:0] n_q, n_d;
    logic [1:0]    m_q, m_d;
    logic [SW-1:0] clr_q, clr_d;
    logic [7:0]    rd_addr_q, rd_addr_d;
    logic          wr_en_q, wr_en_d;
    logic [SW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic [CW-1:0] count_q, count_d;
    logic          sprite0_q, sprite0_d;
    logic          overflow_q, overflow_d;
    logic          done_q, done_d;

    logic [7:0]    entry_base;
    logic [SW-1:0] slot_base;
    logic [9:0]    y_diff;
    logic          in_range;
    logic          slots_full;
    logic          last_entry;
    logic          last_clear;

    assign entry_base = 8'({n_q, 2'b00});
    assign slot_base  = SW'({count_q, 2'b00});
    // Negative difference (sprite starts below the line) shows up as bit 9 set.
    assign y_diff     = {1'b0, lineCount} - {2'b00, oamReadData};
    assign in_range   = !y_diff[9] && (y_diff < (spriteSize ? 10'd16 : 10'd8));
    assign slots_full = (count_q == CW'(SPRITES_PER_LINE));
    assign last_entry = (n_q == NW'(NUM_OAM_ENTRIES - 1));
    assign last_clear = (clr_q == SW'(SPRITES_PER_LINE * 4 - 1));

    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        m_d        = m_q;
        clr_d      = clr_q;
        rd_addr_d  = rd_addr_q;
        wr_en_d    = wr_en_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        count_d    = count_q;
        sprite0_d  = sprite0_q;
        overflow_d = overflow_q;
        done_d     = done_q;

        if (tick) begin
            wr_en_d = 1'b0;
            if (clearOverflow) begin
                overflow_d = 1'b0;
            end
            if (start) begin
                state_d   = CLEAR;
                n_d       = '0;
                m_d       = '0;
                clr_d     = '0;
                count_d   = '0;
                sprite0_d = 1'b0;
                done_d    = 1'b0;
            end else begin
                unique case (state_q)
                    CLEAR: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = clr_q;
                        wr_data_d = 8'hFF;
                        clr_d     = clr_q + SW'(1);
                        if (last_clear) begin
                            state_d = ISSUE_Y;
                        end
                    end
                    ISSUE_Y: begin
                        rd_addr_d = entry_base + 8'(m_q);
                        state_d   = CHECK_Y;
                    end
                    CHECK_Y: begin
                        if (!slots_full && in_range) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = slot_base;
                            wr_data_d = oamReadData;
                            rd_addr_d = entry_base + 8'd1;
                            state_d   = COPY1;
                        end else if (slots_full && in_range) begin
                            overflow_d = 1'b1;
                            done_d     = 1'b1;
                            state_d    = DONE;
                        end else begin
                            // Hardware bug emulation: byte offset walks diagonally once slots are full.
                            if (slots_full && (OVERFLOW_MODE != 0)) begin
                                m_d = m_q + 2'd1;
                            end
                            n_d = n_q + NW'(1);
                            if (last_entry) begin
                                done_d  = 1'b1;
                                state_d = DONE;
                            end else begin
                                state_d = ISSUE_Y;
                            end
                        end
                    end
                    COPY1: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = slot_base + SW'(1);
                        wr_data_d = oamReadData;
                        rd_addr_d = entry_base + 8'd2;
                        state_d   = COPY2;
                    end
                    COPY2: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = slot_base + SW'(2);
                        wr_data_d = oamReadData;
                        rd_addr_d = entry_base + 8'd3;
                        state_d   = COPY3;
                    end
                    COPY3: begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = slot_base + SW'(3);
                        wr_data_d = oamReadData;
                        count_d   = count_q + CW'(1);
                        sprite0_d = sprite0_q | (n_q == '0);
                        n_d       = n_q + NW'(1);
                        if (last_entry) begin
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            state_d = ISSUE_Y;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            n_q        <= '0;
            m_q        <= '0;
            clr_q      <= '0;
            rd_addr_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            count_q    <= '0;
            sprite0_q  <= 1'b0;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            m_q        <= m_d;
            clr_q      <= clr_d;
            rd_addr_q  <= rd_addr_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            count_q    <= count_d;
            sprite0_q  <= sprite0_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
        end
    end

    // A registered strobe is only presented on dot-enabled cycles.
    assign secWrEn        = wr_en_q & tick;
    assign secWrAddr      = wr_addr_q;
    assign secWrData      = wr_data_q;
    assign oamReadAddr    = rd_addr_q;
    assign spriteCount    = count_q;
    assign sprite0InRange = sprite0_q;
    assign spriteOverflow = overflow_q;
    assign done           = done_q;

endmodule

// File: tb/tb_sprite_line_evaluator.sv
// Scoreboard bench for sprite_line_evaluator: two instances (accurate and diagonal-bug overflow)
// share stimulus; a line-level reference model fills per-instance expectation queues.
module tb_sprite_line_evaluator;
    localparam int NUM = 64;
    localparam int SPR = 8;
    localparam int SW  = 5;
    localparam int CW  = 4;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int count;
        int s0;
        int ovf;
        int cost;
    } res_t;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       tick = 1'b1;
    logic       start = 1'b0;
    logic [8:0] lineCount = '0;
    logic       spriteSize = 1'b0;
    logic       clearOverflow = 1'b0;

    logic [1:0][7:0]    rd_addr_v;
    logic [1:0][7:0]    rd_data_v;
    logic [1:0]         we_v;
    logic [1:0][SW-1:0] wa_v;
    logic [1:0][7:0]    wd_v;
    logic [1:0][CW-1:0] cnt_v;
    logic [1:0]         s0_v;
    logic [1:0]         ovf_v;
    logic [1:0]         done_v;

    logic [7:0] oam [256];
    wr_t  exp_wr  [2][$];
    res_t exp_res [2][$];
    int   sticky  [2];
    int   n_checks = 0;
    int   n_fail = 0;
    int   tick_cnt = 0;
    bit   gate = 1'b0;
    bit   ignore_wr = 1'b0;

    always #5 CLK = ~CLK;

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            tick = gate ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(posedge CLK) begin
        if (tick) tick_cnt <= start ? 0 : tick_cnt + 1;
    end

    task automatic check(input string name, input int k, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        sprite_line_evaluator #(
            .NUM_OAM_ENTRIES (NUM),
            .SPRITES_PER_LINE(SPR),
            .OVERFLOW_MODE   (k)
        ) u_dut (
            .CLK           (CLK),
            .RST           (RST),
            .tick          (tick),
            .start         (start),
            .lineCount     (lineCount),
            .spriteSize    (spriteSize),
            .clearOverflow (clearOverflow),
            .oamReadAddr   (rd_addr_v[k]),
            .oamReadData   (rd_data_v[k]),
            .secWrEn       (we_v[k]),
            .secWrAddr     (wa_v[k]),
            .secWrData     (wd_v[k]),
            .spriteCount   (cnt_v[k]),
            .sprite0InRange(s0_v[k]),
            .spriteOverflow(ovf_v[k]),
            .done          (done_v[k])
        );

        assign rd_data_v[k] = oam[rd_addr_v[k]];

        initial begin
            bit   prev_done;
            wr_t  e;
            res_t r;
            prev_done = 1'b1;
            forever begin
                @(negedge CLK);
                if (!RST) begin
                    if (we_v[k] && !ignore_wr) begin
                        if (exp_wr[k].size() == 0) begin
                            check("unexpected_write_addr", k, int'(wa_v[k]), -1);
                        end else begin
                            e = exp_wr[k].pop_front();
                            check("wr_addr", k, int'(wa_v[k]), e.addr);
                            check("wr_data", k, int'(wd_v[k]), e.data);
                        end
                    end
                    if (done_v[k] && !prev_done) begin
                        if (exp_res[k].size() == 0) begin
                            check("unexpected_done", k, 1, 0);
                        end else begin
                            r = exp_res[k].pop_front();
                            check("sprite_count", k, int'(cnt_v[k]), r.count);
                            check("sprite0_in_range", k, int'(s0_v[k]), r.s0);
                            check("overflow", k, int'(ovf_v[k]), r.ovf);
                            check("eval_ticks", k, tick_cnt, r.cost);
                        end
                    end
                end
                prev_done = done_v[k];
            end
        end
    end

    // Line-level reference: which entries land in which slots, and what it costs in ticks.
    task automatic model(input int k, input int line, input int size, output int cost);
        int   h, count, m, y, diff, s0, set_ovf;
        bit   hit;
        wr_t  w;
        res_t r;
        h = size ? 16 : 8;
        count = 0; m = 0; s0 = 0; set_ovf = 0;
        cost = SPR * 4;
        for (int a = 0; a < SPR * 4; a++) begin
            w.addr = a; w.data = 255;
            exp_wr[k].push_back(w);
        end
        for (int n = 0; n < NUM; n++) begin
            y = int'(oam[n * 4 + m]);
            diff = line - y;
            hit = (diff >= 0) && (diff < h);
            cost += 2;
            if (count < SPR && hit) begin
                for (int b = 0; b < 4; b++) begin
                    w.addr = count * 4 + b;
                    w.data = int'(oam[n * 4 + b]);
                    exp_wr[k].push_back(w);
                end
                cost += 3;
                if (n == 0) s0 = 1;
                count++;
            end else if (hit) begin
                set_ovf = 1;
                break;
            end else if (count == SPR && k == 1) begin
                m = (m + 1) % 4;
            end
        end
        r.count = count; r.s0 = s0; r.cost = cost;
        r.ovf = sticky[k] | set_ovf;
        sticky[k] = r.ovf;
        exp_res[k].push_back(r);
    endtask

    task automatic pulse(input bit s, input bit c);
        start = s;
        clearOverflow = c;
        do @(negedge CLK); while (!tick);
        @(posedge CLK);
        #2;
        start = 1'b0;
        clearOverflow = 1'b0;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (done_v != 2'b11 && t < 20000) begin
            @(negedge CLK);
            t++;
        end
        check("done_reached", 0, int'(done_v), 3);
        gate = 1'b0;
        repeat (4) @(negedge CLK);
        for (int k = 0; k < 2; k++) begin
            check("writes_drained", k, exp_wr[k].size(), 0);
            check("results_drained", k, exp_res[k].size(), 0);
        end
    endtask

    task automatic run_line(input int line, input int size);
        int c;
        lineCount = 9'(line);
        spriteSize = size[0];
        model(0, line, size, c);
        model(1, line, size, c);
        pulse(1'b1, 1'b0);
        wait_done();
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 256; i++) oam[i] = v;
    endtask

    task automatic flush();
        for (int k = 0; k < 2; k++) begin
            exp_wr[k].delete();
            exp_res[k].delete();
        end
    endtask

    task automatic check_idle();
        for (int k = 0; k < 2; k++) begin
            check("idle_done", k, int'(done_v[k]), 1);
            check("idle_count", k, int'(cnt_v[k]), 0);
            check("idle_sprite0", k, int'(s0_v[k]), 0);
            check("idle_overflow", k, int'(ovf_v[k]), 0);
            check("idle_oam_addr", k, int'(rd_addr_v[k]), 0);
            check("idle_wr_en", k, int'(we_v[k]), 0);
            check("idle_wr_addr", k, int'(wa_v[k]), 0);
            check("idle_wr_data", k, int'(wd_v[k]), 0);
        end
    endtask

    initial begin
        int cost, line, p, v;
        sticky[0] = 0;
        sticky[1] = 0;
        fill(8'hFF);
        repeat (3) @(posedge CLK);
        #3 RST = 1'b0;
        #1 check_idle();

        // Nothing in range: full clear then a bare 2-tick-per-entry scan.
        fill(8'hFF);
        run_line(100, 0);

        // Entries 0 and 5 copied into slots 0 and 1.
        fill(8'hFF);
        for (int e = 0; e < 64; e += 5) begin
            if (e == 0 || e == 5) begin
                oam[e * 4] = 8'd96; oam[e * 4 + 1] = 8'd11;
                oam[e * 4 + 2] = 8'd22; oam[e * 4 + 3] = 8'd33;
            end
        end
        run_line(100, 0);

        // Nine in range: eight copied, ninth raises overflow.
        fill(8'hFF);
        for (int e = 0; e < 9; e++) oam[e * 4] = 8'd50;
        run_line(55, 0);

        // Sprite height boundary and sprite below the line.
        fill(8'hFF);
        oam[0] = 8'd40;
        run_line(50, 0);
        run_line(50, 1);
        run_line(39, 1);

        // Diagonal read: only the bug-mode instance sees byte 1 of entry 10 as a Y hit.
        pulse(1'b0, 1'b1);
        sticky[0] = 0;
        sticky[1] = 0;
        fill(8'hFF);
        for (int e = 0; e < 9; e++) if (e != 7) oam[e * 4] = 8'd50;
        oam[36] = 8'd0;
        oam[41] = 8'd55;
        run_line(55, 0);

        // Clear alone, then clear on the very tick overflow is set.
        pulse(1'b0, 1'b1);
        sticky[0] = 0;
        sticky[1] = 0;
        @(negedge CLK);
        for (int k = 0; k < 2; k++) check("overflow_cleared", k, int'(ovf_v[k]), 0);
        fill(8'hFF);
        for (int e = 0; e < 9; e++) oam[e * 4] = 8'd50;
        lineCount = 9'd55;
        spriteSize = 1'b0;
        model(0, 55, 0, cost);
        model(1, 55, 0, cost);
        pulse(1'b1, 1'b0);
        repeat (cost - 1) @(posedge CLK);
        #2 clearOverflow = 1'b1;
        @(posedge CLK);
        #2 clearOverflow = 1'b0;
        wait_done();

        // Restart mid-COPY2, then async reset mid-CLEAR.
        fill(8'hFF);
        oam[0] = 8'd96; oam[1] = 8'd11; oam[2] = 8'd22; oam[3] = 8'd33;
        lineCount = 9'd100;
        flush();
        ignore_wr = 1'b1;
        pulse(1'b1, 1'b0);
        repeat (35) @(posedge CLK);
        #2 start = 1'b1;
        @(posedge CLK);
        #2 start = 1'b0;
        ignore_wr = 1'b0;
        model(0, 100, 0, cost);
        model(1, 100, 0, cost);
        repeat (10) @(posedge CLK);
        #3 RST = 1'b1;
        #1 check_idle();
        flush();
        sticky[0] = 0;
        sticky[1] = 0;
        repeat (2) @(posedge CLK);
        #3 RST = 1'b0;
        repeat (20) @(negedge CLK);
        check_idle();

        // Randomised lines, OAM contents, sprite size and dot-enable gaps.
        for (int run = 0; run < 30; run++) begin
            line = $urandom_range(0, 261);
            p = $urandom_range(1, 20);
            for (int e = 0; e < NUM; e++) begin
                if ($urandom_range(0, 63) < p) begin
                    v = line - int'($urandom_range(0, 17));
                    if (v < 0) v = $urandom_range(0, 255);
                end else begin
                    v = $urandom_range(0, 255);
                end
                oam[e * 4] = 8'(v);
                for (int b = 1; b < 4; b++) oam[e * 4 + b] = 8'($urandom_range(0, 255));
            end
            gate = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                pulse(1'b0, 1'b1);
                sticky[0] = 0;
                sticky[1] = 0;
            end
            run_line(line, $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
